// File: rtl/clk_period_monitor_pkg.sv
// Shared types and defaults for the divided-clock period monitor.
package clk_period_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      LOST    = 2'd3
   } state_e;

   localparam int unsigned DEF_FACTOR     = 4;
   localparam int unsigned DEF_TOL        = 1;
   localparam int unsigned DEF_LOCK_COUNT = 4;
   localparam int unsigned DEF_TIMEOUT    = 32;
   localparam int          DEF_CNT_W      = 16;

   // TOL < exp_period keeps the lower bound from underflowing.
   function automatic logic period_in_window(input logic [31:0] period,
                                             input int unsigned exp_period,
                                             input int unsigned tol);
      return (period >= (exp_period - tol)) && (period <= (exp_period + tol));
   endfunction

endpackage

// File: rtl/clk_period_monitor_sync_edge_det.sv
// Two-flop synchroniser with a history flop; rise is combinational from
// registered taps, rise_pulse is the same event one cycle later.
module sync_edge_det (
   input  logic clk_in,
   input  logic rst_n,
   input  logic async_in,
   output logic rise,
   output logic rise_pulse
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;
   logic rise_pulse_q, rise_pulse_d;

   assign rise = s2_q & ~s3_q;

   always_comb begin
      s1_d         = async_in;
      s2_d         = s1_q;
      s3_d         = s2_q;
      rise_pulse_d = rise;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         rise_pulse_q <= 1'b0;
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         rise_pulse_q <= rise_pulse_d;
      end
   end

   assign rise_pulse = rise_pulse_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of a divided clock in clk_in cycles and tracks lock.
//
// state   | meaning
// IDLE    | no previous edge known; waiting for a first rise
// ACQUIRE | counting consecutive in-window periods towards lock
// LOCKED  | period stable; any bad period or timeout drops to LOST
// LOST    | sticky failure; measurement continues until clear
module clk_period_monitor
   import clk_period_monitor_pkg::*;
#(
   parameter int unsigned FACTOR     = DEF_FACTOR,
   parameter int unsigned TOL        = DEF_TOL,
   parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
   parameter int          CNT_W      = DEF_CNT_W
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             clear,
   output logic             edge_pulse,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             locked,
   output logic             lost
);

   localparam int unsigned EXP     = 2 * FACTOR;
   localparam int          MATCH_W = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
   localparam logic [CNT_W-1:0]   CNT_TO     = CNT_W'(TIMEOUT - 1);
   localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_COUNT);

   state_e             state_q, state_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic               period_valid_q, period_valid_d;

   logic               rise;
   logic [CNT_W-1:0]   period_now;
   logic               period_ok;
   logic               timeout;

   sync_edge_det u_sync (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .async_in   (sig_in),
      .rise       (rise),
      .rise_pulse (edge_pulse)
   );

   assign period_now = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
   assign period_ok  = period_in_window(32'(period_now), EXP, TOL);
   // A rise in the terminal cycle takes priority over the timeout.
   assign timeout    = (cnt_q == CNT_TO) && !rise;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         match_q        <= '0;
         cnt_q          <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         match_q        <= match_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      match_d = match_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = ACQUIRE;
               match_d = '0;
            end
         end
         ACQUIRE: begin
            if (rise) begin
               if (period_ok) begin
                  match_d = match_q + 1'b1;
                  if ((match_q + 1'b1) == MATCH_LOCK) state_d = LOCKED;
               end else begin
                  match_d = '0;
               end
            end else if (timeout) begin
               state_d = IDLE;
               match_d = '0;
            end
         end
         LOCKED: begin
            if ((rise && !period_ok) || timeout) state_d = LOST;
         end
         LOST: begin
            if (clear) begin
               state_d = IDLE;
               match_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            match_d = '0;
         end
      endcase
   end

   always_comb begin
      cnt_d          = rise ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
      period_d       = period_q;
      period_valid_d = 1'b0;
      if (rise && (state_q != IDLE)) begin
         period_d       = period_now;
         period_valid_d = 1'b1;
      end
   end

   always_comb begin
      locked       = (state_q == LOCKED);
      lost         = (state_q == LOST);
      period_out   = period_q;
      period_valid = period_valid_q;
   end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor with hand-computed expectations.
module tb_clk_period_monitor;

   logic        clk_in = 1'b0;
   logic        rst_n;
   logic        sig_in;
   logic        clear;
   logic        edge_pulse;
   logic [15:0] period_out;
   logic        period_valid;
   logic        locked;
   logic        lost;

   int checks   = 0;
   int failures = 0;

   clk_period_monitor dut (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .sig_in       (sig_in),
      .clear        (clear),
      .edge_pulse   (edge_pulse),
      .period_out   (period_out),
      .period_valid (period_valid),
      .locked       (locked),
      .lost         (lost)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   // One sig_in period of p cycles (high p/2); rise is sampled one cycle in,
   // so edge_pulse shows in iteration 3. clear is driven during iteration clr_i.
   task automatic send_period(input string tag, input int p, input int clr_i,
                              input logic exp_valid, input int exp_per,
                              input logic exp_lock, input logic exp_lost);
      for (int i = 0; i < p; i++) begin
         @(posedge clk_in); #2;
         sig_in = (i < p / 2);
         clear  = (i == clr_i);
         if (i == 2) begin
            #3;
            check({tag, ".pre_edge"}, 32'(edge_pulse), 0);
         end else if (i == 3) begin
            #3;
            check({tag, ".edge"}, 32'(edge_pulse), 1);
            check({tag, ".valid"}, 32'(period_valid), 32'(exp_valid));
            if (exp_valid) check({tag, ".period"}, 32'(period_out), 32'(exp_per));
            check({tag, ".locked"}, 32'(locked), 32'(exp_lock));
            check({tag, ".lost"}, 32'(lost), 32'(exp_lost));
         end else if (i == 4) begin
            #3;
            check({tag, ".post_edge"}, 32'(edge_pulse), 0);
            check({tag, ".post_valid"}, 32'(period_valid), 0);
         end
      end
      clear = 1'b0;
   endtask

   task automatic pulse_clear();
      @(posedge clk_in); #2;
      clear = 1'b1;
      @(posedge clk_in); #2;
      clear = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      sig_in = 1'b0;
      clear  = 1'b0;
      repeat (2) @(posedge clk_in);
      #2;
      check("rst.locked", 32'(locked), 0);
      check("rst.lost", 32'(lost), 0);
      check("rst.period", 32'(period_out), 0);
      check("rst.valid", 32'(period_valid), 0);
      check("rst.edge", 32'(edge_pulse), 0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk_in);

      // Clean 8-cycle wave: lock on the 5th rise.
      send_period("t1.r1", 8, -1, 1'b0, 0, 1'b0, 1'b0);
      send_period("t1.r2", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t1.r3", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t1.r4", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t1.r5", 8, -1, 1'b1, 8, 1'b1, 1'b0);

      // clear while locked is ignored.
      send_period("t6.clr_locked", 8, 5, 1'b1, 8, 1'b1, 1'b0);
      send_period("t6.after_clr", 8, -1, 1'b1, 8, 1'b1, 1'b0);

      // One 11-cycle period drops lock.
      send_period("t3.r11", 11, -1, 1'b1, 8, 1'b1, 1'b0);
      send_period("t3.bad", 8, -1, 1'b1, 11, 1'b0, 1'b1);
      send_period("t3.stay", 8, -1, 1'b1, 8, 1'b0, 1'b1);

      // clear in LOST returns to IDLE, then relock.
      send_period("t6.clr_lost", 8, 5, 1'b1, 8, 1'b0, 1'b1);
      check("t6.lost_cleared", 32'(lost), 0);
      send_period("t6.r1", 8, -1, 1'b0, 0, 1'b0, 1'b0);
      send_period("t6.r2", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t6.r3", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t6.r4", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t6.r5", 8, -1, 1'b1, 8, 1'b1, 1'b0);

      // Timeout: LOST exactly 32 cycles after the last edge_pulse.
      repeat (27) @(posedge clk_in);
      #3;
      check("t2.before.locked", 32'(locked), 1);
      check("t2.before.lost", 32'(lost), 0);
      @(posedge clk_in); #3;
      check("t2.at.locked", 32'(locked), 0);
      check("t2.at.lost", 32'(lost), 1);
      repeat (40) @(posedge clk_in);
      #3;
      check("t2.hold.locked", 32'(locked), 0);
      check("t2.hold.lost", 32'(lost), 1);
      pulse_clear();
      #3;
      check("t2.cleared", 32'(lost), 0);

      // Jitter 7,9,8,9 all within window.
      send_period("t4a.r1", 7, -1, 1'b0, 0, 1'b0, 1'b0);
      send_period("t4a.r2", 9, -1, 1'b1, 7, 1'b0, 1'b0);
      send_period("t4a.r3", 8, -1, 1'b1, 9, 1'b0, 1'b0);
      send_period("t4a.r4", 9, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t4a.r5", 8, -1, 1'b1, 9, 1'b1, 1'b0);
      repeat (40) @(posedge clk_in);
      #3;
      check("t4a.timeout_lost", 32'(lost), 1);
      pulse_clear();

      // 8,8,11,8,8,8,8: the 11 restarts the match count.
      send_period("t4b.r1", 8, -1, 1'b0, 0, 1'b0, 1'b0);
      send_period("t4b.r2", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t4b.r3", 11, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t4b.r4", 8, -1, 1'b1, 11, 1'b0, 1'b0);
      send_period("t4b.r5", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t4b.r6", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t4b.r7", 8, -1, 1'b1, 8, 1'b0, 1'b0);
      send_period("t4b.r8", 8, -1, 1'b1, 8, 1'b1, 1'b0);

      // Async reset between clock edges.
      check("t5.pre.locked", 32'(locked), 1);
      rst_n = 1'b0;
      #1;
      check("t5.locked", 32'(locked), 0);
      check("t5.lost", 32'(lost), 0);
      check("t5.period", 32'(period_out), 0);
      check("t5.valid", 32'(period_valid), 0);
      #1;
      rst_n = 1'b1;
      send_period("t5.r1", 8, -1, 1'b0, 0, 1'b0, 1'b0);

      // Timeout in ACQUIRE falls back to IDLE: next rise has no period_valid.
      repeat (40) @(posedge clk_in);
      send_period("acq_to.r1", 8, -1, 1'b0, 0, 1'b0, 1'b0);
      send_period("acq_to.r2", 8, -1, 1'b1, 8, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
